// File: rtl/blink_counter.sv
// blink_counter: prescaled WIDTH-bit time base driving the blinker currentCount bus.
// Modes: wrap-around (mode=0) and ping-pong up/down sweep (mode=1), with a
// programmable top limit and a synchronous, clamped load.
// Optional feature macro: BLINK_COUNTER_SNAPSHOT_EN adds snap/snapshot capture.
module blink_counter #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      limit,
   input  logic                  mode,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   output logic [WIDTH-1:0]      count,
   output logic                  tick,
   output logic                  wrap,
   output logic                  dir
`ifdef BLINK_COUNTER_SNAPSHOT_EN
   ,
   input  logic                  snap,
   output logic [WIDTH-1:0]      snapshot
`endif
);

   typedef enum logic {
      ST_UP   = 1'b0,
      ST_DOWN = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_n;
   logic [WIDTH-1:0]        r_count;
   logic [WIDTH-1:0]        w_count_n;
   logic [PRESCALE_W-1:0]   r_pre_cnt;
   logic [PRESCALE_W-1:0]   w_pre_n;
   logic                    r_tick;
   logic                    w_tick_n;
   logic                    r_wrap;
   logic                    w_wrap_n;
   logic                    r_dir;

   logic                    w_step;
   logic                    w_at_top;
   logic [WIDTH-1:0]        w_load_clamp;
   logic [WIDTH-1:0]        w_min_cnt_lim;

   // Step strobe and shared comparisons; a prescale below pre_cnt steps at once
   assign w_step        = (r_pre_cnt >= prescale);
   assign w_at_top      = (r_count >= limit);
   assign w_load_clamp  = (load_value < limit) ? load_value : limit;
   assign w_min_cnt_lim = (r_count < limit) ? r_count : limit;

   // Next-state, next-count and pulse generation
   always_comb begin
      w_state_n = r_state;
      w_count_n = r_count;
      w_pre_n   = r_pre_cnt;
      w_tick_n  = 1'b0;
      w_wrap_n  = 1'b0;

      if (load) begin
         w_count_n = w_load_clamp;
         w_pre_n   = '0;
      end else if (ena) begin
         if (w_step) begin
            w_pre_n  = '0;
            w_tick_n = 1'b1;
            if (!mode) begin
               w_state_n = ST_UP;
               if (w_at_top) begin
                  w_count_n = '0;
                  w_wrap_n  = 1'b1;
               end else begin
                  w_count_n = r_count + WIDTH'(1);
               end
            end else begin
               unique case (r_state)
                  ST_UP: begin
                     if (w_at_top) begin
                        w_state_n = ST_DOWN;
                        w_wrap_n  = 1'b1;
                        w_count_n = (limit == '0) ? '0 : (w_min_cnt_lim - WIDTH'(1));
                     end else begin
                        w_count_n = r_count + WIDTH'(1);
                     end
                  end
                  ST_DOWN: begin
                     if (r_count == '0) begin
                        w_state_n = ST_UP;
                        w_wrap_n  = 1'b1;
                        w_count_n = (limit == '0) ? '0 : WIDTH'(1);
                     end else begin
                        w_count_n = r_count - WIDTH'(1);
                     end
                  end
                  default: w_state_n = ST_UP;
               endcase
            end
         end else begin
            w_pre_n = r_pre_cnt + PRESCALE_W'(1);
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_UP;
         r_count   <= '0;
         r_pre_cnt <= '0;
         r_tick    <= 1'b0;
         r_wrap    <= 1'b0;
         r_dir     <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_count   <= w_count_n;
         r_pre_cnt <= w_pre_n;
         r_tick    <= w_tick_n;
         r_wrap    <= w_wrap_n;
         r_dir     <= (w_state_n == ST_DOWN);
      end
   end

   assign count = r_count;
   assign tick  = r_tick;
   assign wrap  = r_wrap;
   assign dir   = r_dir;

`ifdef BLINK_COUNTER_SNAPSHOT_EN
   logic [WIDTH-1:0] r_snapshot;

   // Capture the pre-update count whenever snap is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snapshot <= '0;
      end else if (snap) begin
         r_snapshot <= r_count;
      end
   end

   assign snapshot = r_snapshot;
`endif

endmodule
